answer_checker: RTL and testbench
=================================

Name: answer_checker

Overview:
- Consumer end of the expression generator's interface: latches one 12-bit expression {num1, op, num2} plus its 2-bit line index.
- Computes the expected answer, collects the player's keypad digits, and compares on ENTER.
- Reports correct/wrong and maintains a running score.
- Sits between the expression generator, the keypad scanner and the display/score logic.

Parameters:
- TIMEOUT_CYCLES, 0, cycles allowed in ENTRY before a forced wrong result; 0 disables the timeout.
- SCORE_W, 8, width of the saturating score counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- exp  in  12  expression: [11:8] num1, [7:4] op (A=add, B=sub, C=mul, D=div), [3:0] num2.
- line  in  2  line index (0..2) belonging to exp.
- load  in  1  one-cycle request to latch exp/line.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- key_code  in  4  0-9 digit, E clear, F enter; A-D ignored.
- busy  out  1  high in ENTRY and CHECK.
- result_valid  out  1  one-cycle pulse when a verdict is produced.
- correct  out  1  verdict, held until next load or rst.
- timed_out  out  1  verdict was forced by timeout, held like correct.
- err  out  1  last load carried a malformed expression, held until next load or rst.
- answer  out  8  expected result in binary, registered at load.
- entered  out  8  player entry as BCD {tens, ones}.
- line_out  out  2  latched line index.
- score  out  SCORE_W  count of correct answers.

Behaviour:
- Reset (rst=1 at clock edge, any state):
  - state=IDLE.
  - All outputs 0; score 0; internal digit count and timer 0.
- FSM states: IDLE, ENTRY, CHECK, RESULT.
- load:
  - Accepted only in IDLE or RESULT; ignored in ENTRY and CHECK.
  - On accept, at the next edge: line_out=line; entered=0; digit count=0; timer=0; correct=0; timed_out=0.
- Validity of a loaded exp: num1 and num2 each in 1..9; op in A..D; for op=B, num1>=num2.
  - Invalid: err=1, answer=0, state IDLE.
  - Valid: err=0, answer registered, state ENTRY.
- Arithmetic (unsigned, 8-bit result):
  - A: num1+num2 (2..18).
  - B: num1-num2 (0..8).
  - C: num1*num2 (1..81).
  - D: floor(num1/num2) (0..9).
- Keys in ENTRY (processed on the edge where key_valid=1):
  - Digit with count=0: entered={0,d}, count=1.
  - Digit with count=1: entered={ones,d}, count=2.
  - Digit with count=2: ignored.
  - E: entered=0, count=0.
  - F with count>=1: go to CHECK.
  - F with count=0: ignored.
  - A-D: ignored.
- CHECK, one cycle:
  - correct = (tens*10 + ones == answer).
  - Score increments on correct and saturates at 2^SCORE_W-1.
  - Next state RESULT; result_valid pulses on this edge.
- Latency: F accepted at edge n -> CHECK during cycle n..n+1 -> result_valid=1 and correct valid in cycle after edge n+1, exactly one cycle.
- Timeout (TIMEOUT_CYCLES>0):
  - Timer counts each ENTRY cycle.
  - When timer reaches TIMEOUT_CYCLES-1 without F: next state CHECK with timed_out=1; verdict forced correct=0; score unchanged.
  - A key strobe on the same edge as timeout expiry is discarded; timeout wins.
- RESULT:
  - Outputs held.
  - load starts a new round; otherwise remain in RESULT.
- rst mid-ENTRY or mid-CHECK: abandons the round; no result_valid; score cleared.
- score is cleared only by rst, never by load.

Test Plan:
- rst, load exp=12'h3A5 line=1, keys 8,F -> answer=8, entered=8'h08, result_valid one cycle two edges after F, correct=1, score=1, line_out=1.
- load exp=12'h7B2, keys 6,F -> answer=5, correct=0, score unchanged; load during ENTRY ignored (line_out/answer stable).
- load exp=12'h9C9, keys 8,1,5,F -> entered=8'h81 (third digit dropped), answer=81, correct=1; SCORE_W=2 with four correct rounds -> score saturates at 3.
- load exp=12'h7D2, keys 4,E,3,F -> entered=8'h03, answer=3, correct=1; F with no digits pressed -> no result, stays busy.
- TIMEOUT_CYCLES=16, load valid exp, no keys -> result_valid after 16 ENTRY cycles, timed_out=1, correct=0; digit strobe on the expiry edge has no effect on entered.
- load exp=12'h0A5 or 12'h3B7 or 12'h3E5 -> err=1, busy=0, no result_valid; rst asserted mid-ENTRY -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/answer_checker_if.sv
// rtl/answer_checker_if.sv - expression/keypad/verdict bundle for answer_checker
//
// Signals driven by the master (the expression generator and keypad side):
//   exp[11:0]  {num1, op, num2}; op A=add, B=sub, C=mul, D=div
//   line[1:0]  line index that belongs to exp
//   load       one-cycle request to latch exp/line
//   key_valid  one-cycle strobe that qualifies key_code
//   key_code   0-9 digit, E clear, F enter
// Signals driven by the slave (answer_checker):
//   busy, result_valid, correct, timed_out, err, answer, entered, line_out, score
interface answer_checker_if #(
    parameter int SCORE_W = 8
);
    logic [11:0]        exp;
    logic [1:0]         line;
    logic               load;
    logic               key_valid;
    logic [3:0]         key_code;

    logic               busy;
    logic               result_valid;
    logic               correct;
    logic               timed_out;
    logic               err;
    logic [7:0]         answer;
    logic [7:0]         entered;
    logic [1:0]         line_out;
    logic [SCORE_W-1:0] score;

    modport master (
        output exp, line, load, key_valid, key_code,
        input  busy, result_valid, correct, timed_out, err,
               answer, entered, line_out, score
    );

    modport slave (
        input  exp, line, load, key_valid, key_code,
        output busy, result_valid, correct, timed_out, err,
               answer, entered, line_out, score
    );
endinterface

// File: rtl/answer_checker.sv
// rtl/answer_checker.sv - latches an expression, collects keypad digits, scores the answer
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  answer_checker_if.slave (expression/load in, keypad in, verdict/score out)
// Parameters:
//   TIMEOUT_CYCLES  ENTRY cycles before a forced wrong verdict; 0 disables
//   SCORE_W         width of the saturating score counter (must match bus)
module answer_checker #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int SCORE_W        = 8
) (
    input  logic           clk,
    input  logic           rst,
    answer_checker_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ENTRY, CHECK, RESULT} state_t;

    state_t             state_q, state_d;
    logic               result_valid_q, result_valid_d;
    logic               correct_q, correct_d;
    logic               timed_out_q, timed_out_d;
    logic               err_q, err_d;
    logic [7:0]         answer_q, answer_d;
    logic [7:0]         entered_q, entered_d;
    logic [1:0]         line_q, line_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         count_q, count_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [3:0] num1, op, num2;
    logic       exp_ok;
    logic [7:0] calc;
    logic       load_ok;
    logic       expired;
    logic       enter_ok;
    logic       is_digit;
    logic [7:0] entered_val;
    logic       match;

    assign num1 = bus.exp[11:8];
    assign op   = bus.exp[7:4];
    assign num2 = bus.exp[3:0];

    // Operand/operator validation and the expected result
    always_comb begin
        exp_ok = (num1 >= 4'd1) && (num1 <= 4'd9) &&
                 (num2 >= 4'd1) && (num2 <= 4'd9) &&
                 (op >= 4'hA) && (op <= 4'hD) &&
                 ((op != 4'hB) || (num1 >= num2));
        case (op)
            4'hA:    calc = 8'(num1) + 8'(num2);
            4'hB:    calc = 8'(num1) - 8'(num2);
            4'hC:    calc = 8'(num1) * 8'(num2);
            4'hD:    calc = (num2 != 4'd0) ? 8'(num1) / 8'(num2) : 8'd0;
            default: calc = 8'd0;
        endcase
    end

    assign load_ok     = bus.load && ((state_q == IDLE) || (state_q == RESULT));
    assign expired     = (TIMEOUT_CYCLES > 0) && (timer_q == T_LAST);
    assign is_digit    = bus.key_code <= 4'd9;
    assign enter_ok    = bus.key_valid && (bus.key_code == 4'hF) && (count_q != 2'd0);
    assign entered_val = 8'(entered_q[7:4]) * 8'd10 + 8'(entered_q[3:0]);
    assign match       = !timed_out_q && (entered_val == answer_q);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            correct_q      <= 1'b0;
            timed_out_q    <= 1'b0;
            err_q          <= 1'b0;
            answer_q       <= 8'd0;
            entered_q      <= 8'd0;
            line_q         <= 2'd0;
            score_q        <= '0;
            count_q        <= 2'd0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
            correct_q      <= correct_d;
            timed_out_q    <= timed_out_d;
            err_q          <= err_d;
            answer_q       <= answer_d;
            entered_q      <= entered_d;
            line_q         <= line_d;
            score_q        <= score_d;
            count_q        <= count_d;
            timer_q        <= timer_d;
        end
    end

    // Next-state logic; timeout takes priority over an ENTER on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESULT: if (load_ok) state_d = exp_ok ? ENTRY : IDLE;
            ENTRY:        if (expired || enter_ok) state_d = CHECK;
            CHECK:        state_d = RESULT;
            default:      state_d = IDLE;
        endcase
    end

    // Datapath/output next values
    always_comb begin
        result_valid_d = 1'b0;
        correct_d      = correct_q;
        timed_out_d    = timed_out_q;
        err_d          = err_q;
        answer_d       = answer_q;
        entered_d      = entered_q;
        line_d         = line_q;
        score_d        = score_q;
        count_d        = count_q;
        timer_d        = timer_q;
        case (state_q)
            IDLE, RESULT: begin
                if (load_ok) begin
                    line_d      = bus.line;
                    entered_d   = 8'd0;
                    count_d     = 2'd0;
                    timer_d     = '0;
                    correct_d   = 1'b0;
                    timed_out_d = 1'b0;
                    err_d       = !exp_ok;
                    answer_d    = exp_ok ? calc : 8'd0;
                end
            end
            ENTRY: begin
                if (expired) begin
                    // Any key on the expiry edge is dropped
                    timed_out_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (bus.key_valid) begin
                        if (is_digit) begin
                            if (count_q == 2'd0) begin
                                entered_d = {4'h0, bus.key_code};
                                count_d   = 2'd1;
                            end else if (count_q == 2'd1) begin
                                entered_d = {entered_q[3:0], bus.key_code};
                                count_d   = 2'd2;
                            end
                        end else if (bus.key_code == 4'hE) begin
                            entered_d = 8'd0;
                            count_d   = 2'd0;
                        end
                    end
                end
            end
            CHECK: begin
                result_valid_d = 1'b1;
                correct_d      = match;
                if (match && (score_q != {SCORE_W{1'b1}})) score_d = score_q + SCORE_W'(1);
            end
            default: ;
        endcase
    end

    assign bus.busy         = (state_q == ENTRY) || (state_q == CHECK);
    assign bus.result_valid = result_valid_q;
    assign bus.correct      = correct_q;
    assign bus.timed_out    = timed_out_q;
    assign bus.err          = err_q;
    assign bus.answer       = answer_q;
    assign bus.entered      = entered_q;
    assign bus.line_out     = line_q;
    assign bus.score        = score_q;
endmodule

// File: tb/tb_answer_checker.sv
// tb/tb_answer_checker.sv - directed self-checking bench for answer_checker
module tb_answer_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    answer_checker_if #(.SCORE_W(2)) bus ();

    answer_checker #(.TIMEOUT_CYCLES(16), .SCORE_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [11:0] e, input logic [1:0] l);
        bus.exp  = e;
        bus.line = l;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_code  = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %0b want 0", bus.result_valid); end
        checks++; if ({bus.correct, bus.timed_out, bus.err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %0b want 000", {bus.correct, bus.timed_out, bus.err}); end
        checks++; if ({bus.answer, bus.entered} !== 16'h0000) begin fails++; $display("FAIL reset_data got %0h want 0000", {bus.answer, bus.entered}); end
        checks++; if ({bus.line_out, bus.score} !== 4'h0) begin fails++; $display("FAIL reset_line_score got %0h want 0", {bus.line_out, bus.score}); end
    endtask

    task automatic test_add();
        do_load(12'h3A5, 2'd1);
        checks++; if (bus.answer !== 8'd8) begin fails++; $display("FAIL add_answer got %0d want 8", bus.answer); end
        checks++; if (bus.line_out !== 2'd1) begin fails++; $display("FAIL add_line got %0d want 1", bus.line_out); end
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL add_busy got %0b want 1", bus.busy); end
        press(4'd8);
        checks++; if (bus.entered !== 8'h08) begin fails++; $display("FAIL add_entered got %0h want 08", bus.entered); end
        press(4'hF);
        checks++; if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL add_rv_early got %0b want 0", bus.result_valid); end
        tick();
        checks++; if (bus.result_valid !== 1'b1) begin fails++; $display("FAIL add_rv got %0b want 1", bus.result_valid); end
        checks++; if (bus.correct !== 1'b1) begin fails++; $display("FAIL add_correct got %0b want 1", bus.correct); end
        checks++; if (bus.score !== 2'd1) begin fails++; $display("FAIL add_score got %0d want 1", bus.score); end
        tick();
        checks++; if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL add_rv_pulse got %0b want 0", bus.result_valid); end
        checks++; if ({bus.busy, bus.correct} !== 2'b01) begin fails++; $display("FAIL add_hold got %0b want 01", {bus.busy, bus.correct}); end
    endtask

    task automatic test_sub_wrong();
        do_load(12'h7B2, 2'd2);
        checks++; if (bus.answer !== 8'd5) begin fails++; $display("FAIL sub_answer got %0d want 5", bus.answer); end
        checks++; if (bus.correct !== 1'b0) begin fails++; $display("FAIL sub_clear_correct got %0b want 0", bus.correct); end
        do_load(12'h3A5, 2'd0);
        checks++; if ({bus.line_out, bus.answer} !== {2'd2, 8'd5}) begin fails++; $display("FAIL sub_load_ignored got %0h want 205", {bus.line_out, bus.answer}); end
        press(4'd6);
        press(4'hF);
        tick();
        checks++; if ({bus.result_valid, bus.correct} !== 2'b10) begin fails++; $display("FAIL sub_verdict got %0b want 10", {bus.result_valid, bus.correct}); end
        checks++; if (bus.score !== 2'd1) begin fails++; $display("FAIL sub_score got %0d want 1", bus.score); end
    endtask

    task automatic test_mul_two_digits();
        do_load(12'h9C9, 2'd0);
        checks++; if (bus.answer !== 8'd81) begin fails++; $display("FAIL mul_answer got %0d want 81", bus.answer); end
        press(4'd8);
        press(4'd1);
        press(4'd5);
        checks++; if (bus.entered !== 8'h81) begin fails++; $display("FAIL mul_entered got %0h want 81", bus.entered); end
        press(4'hF);
        tick();
        checks++; if ({bus.result_valid, bus.correct} !== 2'b11) begin fails++; $display("FAIL mul_verdict got %0b want 11", {bus.result_valid, bus.correct}); end
        checks++; if (bus.score !== 2'd2) begin fails++; $display("FAIL mul_score got %0d want 2", bus.score); end
    endtask

    task automatic test_div_clear();
        do_load(12'h7D2, 2'd1);
        checks++; if (bus.answer !== 8'd3) begin fails++; $display("FAIL div_answer got %0d want 3", bus.answer); end
        press(4'd4);
        press(4'hE);
        checks++; if (bus.entered !== 8'h00) begin fails++; $display("FAIL div_clear got %0h want 00", bus.entered); end
        press(4'hF);
        tick();
        checks++; if ({bus.busy, bus.result_valid} !== 2'b10) begin fails++; $display("FAIL div_empty_enter got %0b want 10", {bus.busy, bus.result_valid}); end
        press(4'hB);
        checks++; if (bus.entered !== 8'h00) begin fails++; $display("FAIL div_letter_key got %0h want 00", bus.entered); end
        press(4'd3);
        press(4'hF);
        tick();
        checks++; if (bus.entered !== 8'h03) begin fails++; $display("FAIL div_entered got %0h want 03", bus.entered); end
        checks++; if ({bus.result_valid, bus.correct, bus.score} !== 4'b1111) begin fails++; $display("FAIL div_verdict got %0b want 1111", {bus.result_valid, bus.correct, bus.score}); end
    endtask

    task automatic test_saturate();
        do_load(12'h9A9, 2'd2);
        checks++; if (bus.answer !== 8'd18) begin fails++; $display("FAIL sat_answer got %0d want 18", bus.answer); end
        press(4'd1);
        press(4'd8);
        press(4'hF);
        tick();
        checks++; if (bus.correct !== 1'b1) begin fails++; $display("FAIL sat_correct got %0b want 1", bus.correct); end
        checks++; if (bus.score !== 2'd3) begin fails++; $display("FAIL sat_score got %0d want 3", bus.score); end
    endtask

    task automatic test_timeout();
        int early_rv = 0;
        do_load(12'h3A5, 2'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.result_valid !== 1'b0 || bus.timed_out !== 1'b0) early_rv++;
        end
        checks++; if (early_rv != 0) begin fails++; $display("FAIL to_early got %0d cycles want 0", early_rv); end
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL to_busy got %0b want 1", bus.busy); end
        press(4'd5);
        checks++; if (bus.timed_out !== 1'b1) begin fails++; $display("FAIL to_flag got %0b want 1", bus.timed_out); end
        checks++; if (bus.entered !== 8'h00) begin fails++; $display("FAIL to_key_dropped got %0h want 00", bus.entered); end
        tick();
        checks++; if ({bus.result_valid, bus.correct, bus.timed_out} !== 3'b101) begin fails++; $display("FAIL to_verdict got %0b want 101", {bus.result_valid, bus.correct, bus.timed_out}); end
        checks++; if (bus.score !== 2'd3) begin fails++; $display("FAIL to_score got %0d want 3", bus.score); end
    endtask

    task automatic test_err();
        int rv_seen = 0;
        do_load(12'h0A5, 2'd0);
        checks++; if ({bus.err, bus.busy, bus.timed_out} !== 3'b100) begin fails++; $display("FAIL err_zero got %0b want 100", {bus.err, bus.busy, bus.timed_out}); end
        checks++; if (bus.answer !== 8'd0) begin fails++; $display("FAIL err_answer got %0d want 0", bus.answer); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.result_valid !== 1'b0) rv_seen++;
        end
        checks++; if (rv_seen != 0) begin fails++; $display("FAIL err_no_result got %0d want 0", rv_seen); end
        do_load(12'h3B7, 2'd1);
        checks++; if ({bus.err, bus.busy} !== 2'b10) begin fails++; $display("FAIL err_sub_neg got %0b want 10", {bus.err, bus.busy}); end
        do_load(12'h3E5, 2'd2);
        checks++; if ({bus.err, bus.busy} !== 2'b10) begin fails++; $display("FAIL err_bad_op got %0b want 10", {bus.err, bus.busy}); end
        do_load(12'h9A9, 2'd2);
        checks++; if ({bus.err, bus.busy, bus.answer} !== {2'b01, 8'd18}) begin fails++; $display("FAIL err_recover got %0h want 112", {bus.err, bus.busy, bus.answer}); end
    endtask

    task automatic test_rst_mid_entry();
        press(4'd4);
        checks++; if (bus.entered !== 8'h04) begin fails++; $display("FAIL rst_pre_entered got %0h want 04", bus.entered); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.busy, bus.result_valid, bus.correct, bus.timed_out, bus.err} !== 5'b0) begin fails++; $display("FAIL rst_mid_flags got %0b want 00000", {bus.busy, bus.result_valid, bus.correct, bus.timed_out, bus.err}); end
        checks++; if ({bus.answer, bus.entered, bus.line_out, bus.score} !== 20'h0) begin fails++; $display("FAIL rst_mid_data got %0h want 0", {bus.answer, bus.entered, bus.line_out, bus.score}); end
        press(4'hF);
        tick();
        checks++; if ({bus.busy, bus.result_valid} !== 2'b00) begin fails++; $display("FAIL rst_mid_idle got %0b want 00", {bus.busy, bus.result_valid}); end
    endtask

    initial begin
        bus.exp       = 12'h000;
        bus.line      = 2'd0;
        bus.load      = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        test_reset();
        test_add();
        test_sub_wrong();
        test_mul_two_digits();
        test_div_clear();
        test_saturate();
        test_timeout();
        test_err();
        test_rst_mid_entry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
